// File: rtl/ibex_pkg.sv
// Shared types for the writeback stage: instruction class, FSM state, latched instruction record.
// No logic here.
// Imported by ibex_wb_stage_lite.
package ibex_pkg;

    // Class of instruction handed from EX to WB; decides whether WB must wait for the LSU.
    typedef enum logic [1:0] {
        WB_INSTR_LOAD  = 2'b00,
        WB_INSTR_STORE = 2'b01,
        WB_INSTR_OTHER = 2'b10
    } wb_instr_type_e;

    // Writeback FSM states.
    typedef enum logic [1:0] {
        WB_EMPTY    = 2'b00,
        WB_HOLD     = 2'b01,
        WB_WAIT_LSU = 2'b10
    } wb_state_e;

    // Everything WB keeps about the instruction it holds.
    typedef struct packed {
        logic [31:0]    pc;
        logic [4:0]     rf_waddr;
        logic [31:0]    rf_wdata;
        logic           rf_we;
        wb_instr_type_e instr_type;
        logic           compressed;
        logic           dummy;
    } wb_instr_t;

    localparam int unsigned WB_INSTR_W = $bits(wb_instr_t);

endpackage

// File: rtl/ibex_wb_stage_lite.sv
// Single-entry writeback stage: latches the EX result, retires it, drives RF write / forwarding / perf pulses.
// Latency: 1 cycle EX->RF for ALU ops; loads/stores retire in the cycle the LSU response arrives.
// Backpressure: ready_wb_o drops while a load/store waits on the LSU; retire and accept overlap (no bubble).
//
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   en_wb_i, instr_type_wb_i, pc_id_i, instr_is_compressed_i, dummy_instr_i,
//   rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i          instruction entering WB
//   lsu_resp_valid_i, lsu_resp_err_i, rf_wdata_lsu_i  LSU response
//   ready_wb_o, outstanding_load_o, outstanding_store_o   stage status to ID/controller
//   pc_wb_o, rf_waddr_wb_o, rf_wdata_wb_o, rf_we_wb_o     register-file write port
//   rf_wdata_fwd_wb_o, rf_write_wb_o                      forwarding / hazard info
//   instr_done_wb_o, perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o, lsu_err_wb_o   retire info
module ibex_wb_stage_lite
    import ibex_pkg::*;
#(
    parameter bit ResetAll   = 1'b0,
    parameter bit DummyInstr = 1'b0
) (
    input  logic           clk_i,
    input  logic           rst_ni,

    input  logic           en_wb_i,
    input  wb_instr_type_e instr_type_wb_i,
    input  logic [31:0]    pc_id_i,
    input  logic           instr_is_compressed_i,
    input  logic           dummy_instr_i,
    input  logic [4:0]     rf_waddr_id_i,
    input  logic [31:0]    rf_wdata_id_i,
    input  logic           rf_we_id_i,

    input  logic           lsu_resp_valid_i,
    input  logic           lsu_resp_err_i,
    input  logic [31:0]    rf_wdata_lsu_i,

    output logic           ready_wb_o,
    output logic           outstanding_load_o,
    output logic           outstanding_store_o,
    output logic [31:0]    pc_wb_o,
    output logic [4:0]     rf_waddr_wb_o,
    output logic [31:0]    rf_wdata_wb_o,
    output logic           rf_we_wb_o,
    output logic [31:0]    rf_wdata_fwd_wb_o,
    output logic           rf_write_wb_o,
    output logic           instr_done_wb_o,
    output logic           perf_instr_ret_wb_o,
    output logic           perf_instr_ret_compressed_wb_o,
    output logic           lsu_err_wb_o
);

    wb_state_e state_q, state_d;
    wb_instr_t instr_q, instr_d;

    logic wb_done;
    logic wb_ready;
    logic wb_latch;
    logic wb_valid;
    logic is_load;
    logic is_store;
    logic wait_lsu;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        wb_done  = 1'b0;
        wb_ready = 1'b0;
        wb_latch = 1'b0;

        case (state_q)
            WB_EMPTY:    wb_done = 1'b0;
            WB_HOLD:     wb_done = 1'b1;
            WB_WAIT_LSU: wb_done = lsu_resp_valid_i;
            default:     wb_done = 1'b0;
        endcase

        wb_ready = (state_q == WB_EMPTY) | wb_done;
        // A request offered while not ready is a protocol violation and is dropped.
        wb_latch = en_wb_i & wb_ready;

        if (wb_done) begin
            state_d = WB_EMPTY;
        end
        // Accept in the retire cycle overrides the return to EMPTY: zero-bubble handover.
        if (wb_latch) begin
            state_d = (instr_type_wb_i == WB_INSTR_OTHER) ? WB_HOLD : WB_WAIT_LSU;
        end
        if ((state_q != WB_EMPTY) && (state_q != WB_HOLD) && (state_q != WB_WAIT_LSU)) begin
            state_d = WB_EMPTY;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= WB_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Instruction record
    // ------------------------------------------------------------------
    always_comb begin
        instr_d            = instr_q;
        instr_d.pc         = pc_id_i;
        instr_d.rf_waddr   = rf_waddr_id_i;
        instr_d.rf_wdata   = rf_wdata_id_i;
        instr_d.rf_we      = rf_we_id_i;
        instr_d.instr_type = instr_type_wb_i;
        instr_d.compressed = instr_is_compressed_i;
        instr_d.dummy      = dummy_instr_i;
    end

    // Every output that reads instr_q is qualified by the FSM state, so the
    // record only needs a reset when deterministic flop contents are wanted.
    generate
        if (ResetAll) begin : g_instr_rst
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    instr_q <= '0;
                end else if (wb_latch) begin
                    instr_q <= instr_d;
                end
            end
        end else begin : g_instr_norst
            always_ff @(posedge clk_i) begin
                if (wb_latch) begin
                    instr_q <= instr_d;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wb_valid = (state_q != WB_EMPTY);
    assign wait_lsu = (state_q == WB_WAIT_LSU);
    assign is_load  = (instr_q.instr_type == WB_INSTR_LOAD);
    assign is_store = (instr_q.instr_type == WB_INSTR_STORE);

    // Held low during reset so nothing upstream sees acceptance before the stage is live.
    assign ready_wb_o          = rst_ni & wb_ready;
    assign outstanding_load_o  = wait_lsu & is_load;
    assign outstanding_store_o = wait_lsu & is_store;

    assign pc_wb_o       = wb_valid ? instr_q.pc       : 32'd0;
    assign rf_waddr_wb_o = wb_valid ? instr_q.rf_waddr : 5'd0;
    assign rf_wdata_wb_o = !wb_valid ? 32'd0 :
                           is_load   ? rf_wdata_lsu_i : instr_q.rf_wdata;

    // Stores never write rd; a faulting load must not update the register file.
    assign rf_we_wb_o = wb_done & instr_q.rf_we & ~is_store & ~(is_load & lsu_resp_err_i);

    // Forwarding data is only meaningful for non-loads; consumers qualify with rf_write_wb_o.
    assign rf_wdata_fwd_wb_o = wb_valid ? instr_q.rf_wdata : 32'd0;
    assign rf_write_wb_o     = wb_valid & instr_q.rf_we & ~is_store;

    assign instr_done_wb_o                = wb_done;
    assign perf_instr_ret_wb_o            = wb_done & ~(DummyInstr & instr_q.dummy);
    assign perf_instr_ret_compressed_wb_o = wb_done & instr_q.compressed;
    assign lsu_err_wb_o                   = wait_lsu & lsu_resp_valid_i & lsu_resp_err_i;

    // ------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------
`ifndef SYNTHESIS
    a_en_while_busy : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(en_wb_i && !wb_ready))
        else $error("wb: en_wb_i asserted while stage busy, request dropped");

    // A response can legitimately arrive after a reset abandoned its load/store,
    // so a stray response is reported but not treated as fatal.
    a_stray_resp : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(lsu_resp_valid_i && !wait_lsu))
        else $warning("wb: lsu response with nothing outstanding, ignored");
`endif

endmodule

// File: tb/tb_ibex_wb_stage_lite.sv
module tb_ibex_wb_stage_lite;
    import ibex_pkg::*;

    logic           clk_i;
    logic           rst_ni;
    logic           en_wb_i;
    wb_instr_type_e instr_type_wb_i;
    logic [31:0]    pc_id_i;
    logic           instr_is_compressed_i;
    logic           dummy_instr_i;
    logic [4:0]     rf_waddr_id_i;
    logic [31:0]    rf_wdata_id_i;
    logic           rf_we_id_i;
    logic           lsu_resp_valid_i;
    logic           lsu_resp_err_i;
    logic [31:0]    rf_wdata_lsu_i;
    logic           ready_wb_o;
    logic           outstanding_load_o;
    logic           outstanding_store_o;
    logic [31:0]    pc_wb_o;
    logic [4:0]     rf_waddr_wb_o;
    logic [31:0]    rf_wdata_wb_o;
    logic           rf_we_wb_o;
    logic [31:0]    rf_wdata_fwd_wb_o;
    logic           rf_write_wb_o;
    logic           instr_done_wb_o;
    logic           perf_instr_ret_wb_o;
    logic           perf_instr_ret_compressed_wb_o;
    logic           lsu_err_wb_o;

    int total;
    int bad;

    ibex_wb_stage_lite #(
        .ResetAll   (1'b0),
        .DummyInstr (1'b1)
    ) dut (
        .clk_i                          (clk_i),
        .rst_ni                         (rst_ni),
        .en_wb_i                        (en_wb_i),
        .instr_type_wb_i                (instr_type_wb_i),
        .pc_id_i                        (pc_id_i),
        .instr_is_compressed_i          (instr_is_compressed_i),
        .dummy_instr_i                  (dummy_instr_i),
        .rf_waddr_id_i                  (rf_waddr_id_i),
        .rf_wdata_id_i                  (rf_wdata_id_i),
        .rf_we_id_i                     (rf_we_id_i),
        .lsu_resp_valid_i               (lsu_resp_valid_i),
        .lsu_resp_err_i                 (lsu_resp_err_i),
        .rf_wdata_lsu_i                 (rf_wdata_lsu_i),
        .ready_wb_o                     (ready_wb_o),
        .outstanding_load_o             (outstanding_load_o),
        .outstanding_store_o            (outstanding_store_o),
        .pc_wb_o                        (pc_wb_o),
        .rf_waddr_wb_o                  (rf_waddr_wb_o),
        .rf_wdata_wb_o                  (rf_wdata_wb_o),
        .rf_we_wb_o                     (rf_we_wb_o),
        .rf_wdata_fwd_wb_o              (rf_wdata_fwd_wb_o),
        .rf_write_wb_o                  (rf_write_wb_o),
        .instr_done_wb_o                (instr_done_wb_o),
        .perf_instr_ret_wb_o            (perf_instr_ret_wb_o),
        .perf_instr_ret_compressed_wb_o (perf_instr_ret_compressed_wb_o),
        .lsu_err_wb_o                   (lsu_err_wb_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        en_wb_i               = 1'b0;
        instr_type_wb_i       = WB_INSTR_OTHER;
        pc_id_i               = 32'd0;
        instr_is_compressed_i = 1'b0;
        dummy_instr_i         = 1'b0;
        rf_waddr_id_i         = 5'd0;
        rf_wdata_id_i         = 32'd0;
        rf_we_id_i            = 1'b0;
        lsu_resp_valid_i      = 1'b0;
        lsu_resp_err_i        = 1'b0;
        rf_wdata_lsu_i        = 32'd0;
    endtask

    task automatic offer(input wb_instr_type_e t, input logic [31:0] pc, input logic [4:0] rd,
                         input logic [31:0] wd, input logic we, input logic comp, input logic dum);
        en_wb_i               = 1'b1;
        instr_type_wb_i       = t;
        pc_id_i               = pc;
        rf_waddr_id_i         = rd;
        rf_wdata_id_i         = wd;
        rf_we_id_i            = we;
        instr_is_compressed_i = comp;
        dummy_instr_i         = dum;
    endtask

    task automatic resp(input logic err, input logic [31:0] data);
        lsu_resp_valid_i = 1'b1;
        lsu_resp_err_i   = err;
        rf_wdata_lsu_i   = data;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_ni = 1'b0;
        idle();

        // ---------------- reset state ----------------
        #3;
        chk("rst_ready",  {31'd0, ready_wb_o}, 32'd0);
        chk("rst_we",     {31'd0, rf_we_wb_o}, 32'd0);
        chk("rst_done",   {31'd0, instr_done_wb_o}, 32'd0);
        chk("rst_pc",     pc_wb_o, 32'd0);
        chk("rst_wdata",  rf_wdata_wb_o, 32'd0);
        chk("rst_write",  {31'd0, rf_write_wb_o}, 32'd0);
        nxt();
        nxt();
        rst_ni = 1'b1;
        nxt();

        // ---------------- back-to-back ALU ----------------
        offer(WB_INSTR_OTHER, 32'h100, 5'd5, 32'd1, 1'b1, 1'b0, 1'b0);
        #2;
        chk("alu0_ready", {31'd0, ready_wb_o}, 32'd1);
        chk("alu0_we",    {31'd0, rf_we_wb_o}, 32'd0);
        nxt();
        offer(WB_INSTR_OTHER, 32'h104, 5'd6, 32'd2, 1'b1, 1'b0, 1'b0);
        #2;
        chk("alu1_we",    {31'd0, rf_we_wb_o}, 32'd1);
        chk("alu1_addr",  {27'd0, rf_waddr_wb_o}, 32'd5);
        chk("alu1_data",  rf_wdata_wb_o, 32'd1);
        chk("alu1_ready", {31'd0, ready_wb_o}, 32'd1);
        chk("alu1_pc",    pc_wb_o, 32'h100);
        chk("alu1_fwd",   rf_wdata_fwd_wb_o, 32'd1);
        nxt();
        offer(WB_INSTR_OTHER, 32'h108, 5'd7, 32'd3, 1'b1, 1'b0, 1'b0);
        #2;
        chk("alu2_we",    {31'd0, rf_we_wb_o}, 32'd1);
        chk("alu2_addr",  {27'd0, rf_waddr_wb_o}, 32'd6);
        chk("alu2_data",  rf_wdata_wb_o, 32'd2);
        chk("alu2_ready", {31'd0, ready_wb_o}, 32'd1);
        nxt();
        idle();
        #2;
        chk("alu3_we",    {31'd0, rf_we_wb_o}, 32'd1);
        chk("alu3_addr",  {27'd0, rf_waddr_wb_o}, 32'd7);
        chk("alu3_data",  rf_wdata_wb_o, 32'd3);
        chk("alu3_perf",  {31'd0, perf_instr_ret_wb_o}, 32'd1);
        nxt();
        #2;
        chk("alu4_we",    {31'd0, rf_we_wb_o}, 32'd0);
        chk("alu4_done",  {31'd0, instr_done_wb_o}, 32'd0);

        // ---------------- load, response 3 cycles late ----------------
        offer(WB_INSTR_LOAD, 32'h200, 5'd10, 32'h1234, 1'b1, 1'b0, 1'b0);
        nxt();
        idle();
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("ld_wait_ready", {31'd0, ready_wb_o}, 32'd0);
            chk("ld_wait_out",   {31'd0, outstanding_load_o}, 32'd1);
            chk("ld_wait_we",    {31'd0, rf_we_wb_o}, 32'd0);
            nxt();
        end
        resp(1'b0, 32'hDEADBEEF);
        #2;
        chk("ld_we",     {31'd0, rf_we_wb_o}, 32'd1);
        chk("ld_addr",   {27'd0, rf_waddr_wb_o}, 32'd10);
        chk("ld_data",   rf_wdata_wb_o, 32'hDEADBEEF);
        chk("ld_done",   {31'd0, instr_done_wb_o}, 32'd1);
        chk("ld_err",    {31'd0, lsu_err_wb_o}, 32'd0);
        chk("ld_pc",     pc_wb_o, 32'h200);
        nxt();
        idle();
        #2;
        chk("ld_after_we",  {31'd0, rf_we_wb_o}, 32'd0);
        chk("ld_after_out", {31'd0, outstanding_load_o}, 32'd0);
        nxt();

        // ---------------- load with bus error ----------------
        offer(WB_INSTR_LOAD, 32'h300, 5'd11, 32'd0, 1'b1, 1'b0, 1'b0);
        nxt();
        idle();
        resp(1'b1, 32'hCAFEF00D);
        #2;
        chk("lderr_we",   {31'd0, rf_we_wb_o}, 32'd0);
        chk("lderr_err",  {31'd0, lsu_err_wb_o}, 32'd1);
        chk("lderr_done", {31'd0, instr_done_wb_o}, 32'd1);
        nxt();
        idle();

        // ---------------- store retiring with ALU op offered ----------------
        offer(WB_INSTR_STORE, 32'h400, 5'd3, 32'h99, 1'b0, 1'b0, 1'b0);
        nxt();
        idle();
        #2;
        chk("st_out",   {31'd0, outstanding_store_o}, 32'd1);
        chk("st_ready", {31'd0, ready_wb_o}, 32'd0);
        chk("st_write", {31'd0, rf_write_wb_o}, 32'd0);
        nxt();
        resp(1'b0, 32'h0);
        offer(WB_INSTR_OTHER, 32'h404, 5'd12, 32'h55, 1'b1, 1'b0, 1'b0);
        #2;
        chk("st_done",  {31'd0, instr_done_wb_o}, 32'd1);
        chk("st_we",    {31'd0, rf_we_wb_o}, 32'd0);
        chk("st_ready2",{31'd0, ready_wb_o}, 32'd1);
        nxt();
        idle();
        #2;
        chk("st_alu_we",   {31'd0, rf_we_wb_o}, 32'd1);
        chk("st_alu_addr", {27'd0, rf_waddr_wb_o}, 32'd12);
        chk("st_alu_data", rf_wdata_wb_o, 32'h55);
        nxt();

        // ---------------- compressed dummy ----------------
        offer(WB_INSTR_OTHER, 32'h500, 5'd3, 32'h7, 1'b1, 1'b1, 1'b1);
        nxt();
        offer(WB_INSTR_OTHER, 32'h502, 5'd4, 32'h8, 1'b1, 1'b1, 1'b0);
        #2;
        chk("dum_perf",  {31'd0, perf_instr_ret_wb_o}, 32'd0);
        chk("dum_perfc", {31'd0, perf_instr_ret_compressed_wb_o}, 32'd1);
        chk("dum_done",  {31'd0, instr_done_wb_o}, 32'd1);
        nxt();
        idle();
        #2;
        chk("cmp_perf",  {31'd0, perf_instr_ret_wb_o}, 32'd1);
        chk("cmp_perfc", {31'd0, perf_instr_ret_compressed_wb_o}, 32'd1);
        nxt();

        // ---------------- reset during WAIT_LSU ----------------
        offer(WB_INSTR_LOAD, 32'h600, 5'd9, 32'd0, 1'b1, 1'b0, 1'b0);
        nxt();
        idle();
        #2;
        chk("rw_out_pre", {31'd0, outstanding_load_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("rw_out",   {31'd0, outstanding_load_o}, 32'd0);
        chk("rw_ready", {31'd0, ready_wb_o}, 32'd0);
        chk("rw_pc",    pc_wb_o, 32'd0);
        chk("rw_write", {31'd0, rf_write_wb_o}, 32'd0);
        nxt();
        nxt();
        rst_ni = 1'b1;
        nxt();
        resp(1'b1, 32'h13572468);
        #2;
        chk("rw_late_we",   {31'd0, rf_we_wb_o}, 32'd0);
        chk("rw_late_done", {31'd0, instr_done_wb_o}, 32'd0);
        chk("rw_late_err",  {31'd0, lsu_err_wb_o}, 32'd0);
        chk("rw_late_rdy",  {31'd0, ready_wb_o}, 32'd1);
        nxt();
        idle();
        nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
